// File: rtl/data_path_ctrl.sv
// Sequencing controller for the 16-bit accumulator datapath: accepts one command,
// streams operands into the load strobes, fires the op, waits for done, then acks.
module data_path_ctrl #(
  parameter int W       = 16,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   cmd_op,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  input  logic [W-1:0] cmd_o,
  output logic         busy,
  output logic         ack,
  output logic         err,
  output logic         ldA,
  output logic         ldB,
  output logic         ldO,
  output logic [W-1:0] d_in,
  output logic [1:0]   op_code,
  input  logic         done
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LD_A,
    LD_B,
    LD_O,
    EXEC,
    WAIT,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  o_q, o_d;
  logic          err_d, ld_a_d, ld_b_d, ld_o_d, busy_d, ack_d;
  logic [W-1:0]  d_in_d;
  logic [1:0]    op_code_d;

  // Outputs are computed for the state being entered, so they register in step with it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    b_d       = b_q;
    o_d       = o_q;
    err_d     = err;
    ld_a_d    = 1'b0;
    ld_b_d    = 1'b0;
    ld_o_d    = 1'b0;
    d_in_d    = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = cmd_op;
          b_d   = cmd_b;
          o_d   = cmd_o;
          err_d = 1'b0;
          if (cmd_op == 2'b00 && cmd_b == '0) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = LD_A;
            ld_a_d  = 1'b1;
            d_in_d  = cmd_a;
          end
        end
      end
      LD_A: begin
        state_d = LD_B;
        ld_b_d  = 1'b1;
        d_in_d  = b_q;
      end
      LD_B: begin
        state_d = LD_O;
        ld_o_d  = 1'b1;
        d_in_d  = o_q;
      end
      LD_O: begin
        state_d = EXEC;
        ld_a_d  = 1'b1;
      end
      EXEC: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (done) begin
          state_d = RESP;
          err_d   = 1'b0;
        end else if (cnt_q == LAST) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    ack_d     = (state_d == RESP);
    op_code_d = (state_d == IDLE) ? 2'b00 : op_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 2'b00;
      b_q     <= '0;
      o_q     <= '0;
      busy    <= 1'b0;
      ack     <= 1'b0;
      err     <= 1'b0;
      ldA     <= 1'b0;
      ldB     <= 1'b0;
      ldO     <= 1'b0;
      d_in    <= '0;
      op_code <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      o_q     <= o_d;
      busy    <= busy_d;
      ack     <= ack_d;
      err     <= err_d;
      ldA     <= ld_a_d;
      ldB     <= ld_b_d;
      ldO     <= ld_o_d;
      d_in    <= d_in_d;
      op_code <= op_code_d;
    end
  end

endmodule

// File: tb/tb_data_path_ctrl.sv
// Directed bench for data_path_ctrl: a vector table for the basic flows plus
// hand-written sequences for timeout, ignored starts, mid-flight reset and back-to-back.
module tb_data_path_ctrl;

  localparam int W       = 16;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst, start, done;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_a, cmd_b, cmd_o;
  logic         busy, ack, err, ldA, ldB, ldO;
  logic [W-1:0] d_in;
  logic [1:0]   op_code;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  data_path_ctrl #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_o(cmd_o),
    .busy(busy), .ack(ack), .err(err),
    .ldA(ldA), .ldB(ldB), .ldO(ldO),
    .d_in(d_in), .op_code(op_code), .done(done)
  );

  // ctl = {rst, start, done}; flags = {busy, ack, err, ldA, ldB, ldO}, both as seen after the edge
  typedef struct {
    logic [2:0]   ctl;
    logic [1:0]   op;
    logic [W-1:0] a, b, o;
    logic [5:0]   flags;
    logic [W-1:0] d_in;
    logic [1:0]   opc;
  } vec_t;

  vec_t vecs[17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    {rst, start, done} = v.ctl;
    cmd_op = v.op;
    cmd_a  = v.a;
    cmd_b  = v.b;
    cmd_o  = v.o;
  endtask

  function automatic logic [5:0] flagsNow();
    return {busy, ack, err, ldA, ldB, ldO};
  endfunction

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, b, o);
    start  = 1'b1;
    cmd_op = op;
    cmd_a  = a;
    cmd_b  = b;
    cmd_o  = o;
    step();
    start  = 1'b0;
    cmd_op = 2'b01;
    cmd_a  = 16'hDEAD;
    cmd_b  = 16'hBEEF;
    cmd_o  = 16'hCAFE;
  endtask

  // Latency counts edges from the accept edge (1) up to the edge that raises ack.
  task automatic runCommand(input string name, input logic [1:0] op, input logic [W-1:0] a, b, o,
                            input int exp_lat, input logic exp_err);
    int lat;
    issue(op, a, b, o);
    lat = 1;
    while (!ack && lat < 60) begin
      step();
      lat++;
    end
    if (!ack) begin
      checkOutput({name, ".ack_seen"}, 32'd0, 32'd1);
    end else begin
      checkOutput({name, ".latency"}, 32'(lat), 32'(exp_lat));
      checkOutput({name, ".err"}, 32'(err), 32'(exp_err));
    end
    step();
    checkOutput({name, ".idle_after"}, 32'({busy, ack}), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0]  = '{3'b100, 2'b00, 16'd0,    16'd0,    16'd0,    6'b000000, 16'd0, 2'b00};
    vecs[1]  = '{3'b011, 2'b01, 16'd5,    16'd3,    16'd9,    6'b100100, 16'd5, 2'b01};
    vecs[2]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b100010, 16'd3, 2'b01};
    vecs[3]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b100001, 16'd9, 2'b01};
    vecs[4]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b100100, 16'd0, 2'b01};
    vecs[5]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b100000, 16'd0, 2'b01};
    vecs[6]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b110000, 16'd0, 2'b01};
    vecs[7]  = '{3'b001, 2'b11, 16'd77,   16'd66,   16'd55,   6'b000000, 16'd0, 2'b00};
    vecs[8]  = '{3'b011, 2'b00, 16'd8,    16'd0,    16'd1,    6'b111000, 16'd0, 2'b00};
    vecs[9]  = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b001000, 16'd0, 2'b00};
    vecs[10] = '{3'b011, 2'b00, 16'd8,    16'd2,    16'd4,    6'b100100, 16'd8, 2'b00};
    vecs[11] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b100010, 16'd2, 2'b00};
    vecs[12] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b100001, 16'd4, 2'b00};
    vecs[13] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b100100, 16'd0, 2'b00};
    vecs[14] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b100000, 16'd0, 2'b00};
    vecs[15] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b110000, 16'd0, 2'b00};
    vecs[16] = '{3'b001, 2'b10, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'b000000, 16'd0, 2'b00};

    rst = 1'b1; start = 1'b0; done = 1'b0;
    cmd_op = 2'b00; cmd_a = '0; cmd_b = '0; cmd_o = '0;

    $display("[TB] table vectors: add flow, div-by-zero, div with nonzero divisor");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i]);
      step();
      checkOutput($sformatf("v%0d.flags", i), 32'(flagsNow()), 32'(vecs[i].flags));
      checkOutput($sformatf("v%0d.d_in", i), 32'(d_in), 32'(vecs[i].d_in));
      checkOutput($sformatf("v%0d.op_code", i), 32'(op_code), 32'(vecs[i].opc));
    end

    $display("[TB] timeout with done held low, then a clean command");
    done = 1'b0;
    runCommand("timeout", 2'b11, 16'd1, 16'd2, 16'd3, 5 + TIMEOUT, 1'b1);
    done = 1'b1;
    runCommand("after_timeout", 2'b10, 16'd7, 16'd3, 16'd1, 6, 1'b0);

    $display("[TB] start pulses while busy are ignored");
    begin
      int extra;
      done = 1'b0;
      issue(2'b01, 16'd10, 16'd20, 16'd30);
      checkOutput("ignore.lda_flags", 32'(flagsNow()), 32'(6'b100100));
      checkOutput("ignore.lda_d_in", 32'(d_in), 32'd10);
      step();
      start = 1'b1; cmd_op = 2'b11; cmd_a = 16'd99; cmd_b = 16'd98; cmd_o = 16'd97;
      step();
      start = 1'b0;
      checkOutput("ignore.ldo_flags", 32'(flagsNow()), 32'(6'b100001));
      checkOutput("ignore.ldo_d_in", 32'(d_in), 32'd30);
      checkOutput("ignore.ldo_op_code", 32'(op_code), 32'(2'b01));
      step();
      step();
      checkOutput("ignore.wait_flags", 32'(flagsNow()), 32'(6'b100000));
      start = 1'b1; cmd_op = 2'b00; cmd_b = 16'd0;
      step();
      start = 1'b0;
      checkOutput("ignore.wait_hold", 32'(flagsNow()), 32'(6'b100000));
      done = 1'b1;
      step();
      checkOutput("ignore.resp_flags", 32'(flagsNow()), 32'(6'b110000));
      checkOutput("ignore.resp_op_code", 32'(op_code), 32'(2'b01));
      extra = 0;
      repeat (5) begin
        step();
        if (ack) extra++;
      end
      checkOutput("ignore.extra_acks", 32'(extra), 32'd0);
    end

    $display("[TB] reset during LD_O drops the command");
    begin
      int acks;
      done = 1'b1;
      issue(2'b10, 16'd4, 16'd5, 16'd6);
      step();
      step();
      checkOutput("rst.ldo_flags", 32'(flagsNow()), 32'(6'b100001));
      checkOutput("rst.ldo_d_in", 32'(d_in), 32'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checkOutput("rst.flags", 32'(flagsNow()), 32'(6'b000000));
      checkOutput("rst.d_in", 32'(d_in), 32'd0);
      checkOutput("rst.op_code", 32'(op_code), 32'(2'b00));
      acks = 0;
      repeat (8) begin
        step();
        if (ack) acks++;
      end
      checkOutput("rst.dropped_ack", 32'(acks), 32'd0);
      runCommand("post_reset", 2'b01, 16'd11, 16'd12, 16'd13, 6, 1'b0);
    end

    $display("[TB] start held high: back-to-back commands");
    begin
      int acks;
      int ph;
      done = 1'b1;
      start = 1'b1; cmd_op = 2'b01; cmd_a = 16'd1; cmd_b = 16'd2; cmd_o = 16'd3;
      acks = 0;
      for (int n = 1; n <= 35; n++) begin
        step();
        ph = n % 7;
        if (ack) acks++;
        checkOutput($sformatf("b2b.ack@%0d", n), 32'(ack), 32'(ph == 6));
        checkOutput($sformatf("b2b.ldA@%0d", n), 32'(ldA), 32'(ph == 1 || ph == 4));
        checkOutput($sformatf("b2b.onehot@%0d", n), 32'($countones({ldA, ldB, ldO}) <= 1), 32'd1);
      end
      checkOutput("b2b.ack_count", 32'(acks), 32'd5);
      start = 1'b0;
      step();
      checkOutput("b2b.idle_busy", 32'(busy), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
